// File: rtl/seg_scan_lxy.sv
// Time-multiplexed hex scanner for a common-anode 7-segment bank with frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_lxy #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [3:0]            digit_data,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int VAL_W = 4 * DIGITS;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  active_q, active_d;
  logic [VAL_W-1:0]  pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]        digit_data_q, digit_data_d;
  logic              frame_done_q, frame_done_d;

  logic tick;
  logic wrap;

`ifdef SEG_SCAN_LZB_EN
  logic [IDX_W-1:0] msd;
  logic             blank;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tick         = (div_q == DIV_LAST);
    wrap         = tick && (idx_q == IDX_LAST);
    div_d        = tick ? '0 : div_q + 1'b1;
    idx_d        = idx_q;
    active_d     = active_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    wrap_d       = wrap;
    frame_done_d = wrap_q;
    digit_data_d = 4'h0;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // A load in the wrap cycle bypasses the pending register entirely.
    if (wrap) begin
      if (load) begin
        active_d = data_in;
      end else if (pend_q) begin
        active_d = pend_val_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_val_d = data_in;
      pend_d     = 1'b1;
    end

    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit_data_d = active_q[4*k +: 4];
      end
    end

    digit_sel_d = ~(DIGITS'(1) << idx_q);

`ifdef SEG_SCAN_LZB_EN
    msd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (active_q[4*k +: 4] != 4'h0) begin
        msd = IDX_W'(k);
      end
    end
    blank = (idx_q > msd);
    if (blank) begin
      digit_sel_d = '1;
    end
`endif
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      wrap_q       <= 1'b0;
      digit_sel_q  <= '1;
      digit_data_q <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      wrap_q       <= wrap_d;
      digit_sel_q  <= digit_sel_d;
      digit_data_q <= digit_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_sel  = digit_sel_q;
  assign digit_data = digit_data_q;
  assign frame_done = frame_done_q;

endmodule
